// File: rtl/hexdisp_pkg.sv
// hexdisp_pkg: shared types and segment constants for the hex display controller
package hexdisp_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  typedef enum logic {MODE_SW, MODE_CPU} mode_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational hex digit to active-low seven-segment decoder
module hex7seg
  import hexdisp_pkg::*;
(
  input  logic [3:0] d,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[d];
endmodule

// File: rtl/hexdisp_ctrl.sv
// hexdisp_ctrl: shares eight HEX digits between switches and CPU via one time-shared decoder
module hexdisp_ctrl
  import hexdisp_pkg::*;
#(
  parameter int SW_W = 18,
  parameter int NDIG = 8
) (
  input  logic            CLOCK_50,
  input  logic            rst,
  input  logic [SW_W-1:0] SW,
  input  logic            cpu_we,
  input  logic [31:0]     cpu_data,
  input  logic            cpu_release,
  input  logic            blank_lz,
  output logic            cpu_ready,
  output logic            busy,
  output logic            done,
  output logic [6:0]      HEX0,
  output logic [6:0]      HEX1,
  output logic [6:0]      HEX2,
  output logic [6:0]      HEX3,
  output logic [6:0]      HEX4,
  output logic [6:0]      HEX5,
  output logic [6:0]      HEX6,
  output logic [6:0]      HEX7
);
  state_t state, state_n;
  mode_t mode;
  logic [31:0] val;
  logic [2:0] idx;
  logic [SW_W-1:0] last_sw;
  logic blz, nz, pend, rel_pend, rel, acc;
  logic [3:0] d;
  logic [6:0] seg;
  logic [6:0] shadow [NDIG];
  logic [6:0] hex [NDIG];
  assign d = val[{idx, 2'b00} +: 4];
  hex7seg u_dec (.d(d), .seg(seg));
  assign rel = cpu_release | rel_pend;
  assign acc = state == IDLE && (cpu_we || rel || (mode == MODE_SW && (SW != last_sw || pend)));
  assign cpu_ready = state == IDLE;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state == IDLE ? (acc ? SCAN : IDLE) :
              state == SCAN ? (idx == 3'd0 ? COMMIT : SCAN) : IDLE;
  end
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state <= IDLE;
      mode <= MODE_SW;
      pend <= 1'b1;
      rel_pend <= 1'b0;
      last_sw <= '0;
      done <= 1'b0;
      val <= '0;
      idx <= '0;
      nz <= 1'b0;
      blz <= 1'b0;
      hex <= '{default: SEG_BLANK};
    end else begin
      state <= state_n;
      done <= state == COMMIT;
      // a release seen while busy waits; any acceptance consumes or drops it
      rel_pend <= !acc && (rel_pend || cpu_release);
      if (acc) begin
        val <= cpu_we ? cpu_data : 32'(SW);
        mode <= cpu_we ? MODE_CPU : MODE_SW;
        if (!cpu_we) last_sw <= SW;
        blz <= blank_lz;
        idx <= 3'd7;
        nz <= 1'b0;
        pend <= 1'b0;
      end
      if (state == SCAN) begin
        shadow[idx] <= (blz && !nz && d == 4'd0 && idx != 3'd0) ? SEG_BLANK : seg;
        nz <= nz | (d != 4'd0);
        idx <= idx - 3'd1;
      end
      if (state == COMMIT) hex <= shadow;
    end
  end
  assign HEX0 = hex[0];
  assign HEX1 = hex[1];
  assign HEX2 = hex[2];
  assign HEX3 = hex[3];
  assign HEX4 = hex[4];
  assign HEX5 = hex[5];
  assign HEX6 = hex[6];
  assign HEX7 = hex[7];
endmodule

// File: tb/tb_hexdisp_ctrl.sv
// tb_hexdisp_ctrl: scoreboard bench with a digit-level reference model of the display
module tb_hexdisp_ctrl;
  logic clk = 0, rst = 1;
  logic [17:0] sw = 0;
  logic cpu_we = 0, cpu_release = 0, blank_lz = 0;
  logic [31:0] cpu_data = 0;
  logic cpu_ready, busy, done;
  logic [6:0] h0, h1, h2, h3, h4, h5, h6, h7;
  logic [55:0] disp;
  logic [55:0] q [$];
  int checks = 0, errors = 0;
  logic model_cpu = 0;
  logic [17:0] model_last = 0;
  logic [6:0] seg_ref [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  always #5 clk = ~clk;
  hexdisp_ctrl dut (
    .CLOCK_50(clk), .rst(rst), .SW(sw), .cpu_we(cpu_we), .cpu_data(cpu_data),
    .cpu_release(cpu_release), .blank_lz(blank_lz), .cpu_ready(cpu_ready),
    .busy(busy), .done(done), .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3),
    .HEX4(h4), .HEX5(h5), .HEX6(h6), .HEX7(h7)
  );
  assign disp = {h7, h6, h5, h4, h3, h2, h1, h0};

  // Expected panel {HEX7..HEX0}: digits above the most significant nonzero one blank when requested
  function automatic logic [55:0] expect_disp(input logic [31:0] v, input logic blz);
    logic [55:0] r;
    int top;
    top = 0;
    for (int k = 0; k < 8; k++) if (((v >> (4 * k)) & 32'hF) != 0) top = k;
    for (int k = 0; k < 8; k++)
      r[7*k +: 7] = (blz && k > top) ? 7'h7F : seg_ref[(v >> (4 * k)) & 32'hF];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done display=%h", disp);
      end else chk("display", 64'(disp), 64'(q.pop_front()));
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cpu_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_ready) chk("ready_timeout", 64'(cpu_ready), 64'd1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic cpu_write(input logic [31:0] v);
    cpu_we = 1;
    cpu_data = v;
    q.push_back(expect_disp(v, blank_lz));
    model_cpu = 1;
    @(negedge clk);
    cpu_we = 0;
  endtask

  task automatic release_pulse();
    cpu_release = 1;
    q.push_back(expect_disp(32'(sw), blank_lz));
    model_cpu = 0;
    model_last = sw;
    @(negedge clk);
    cpu_release = 0;
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    logic [55:0] beef;
    beef = {7'b0100001, 7'b0000110, 7'b0001000, 7'b0100001,
            7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110};
    sw = 18'h36895;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hex", 64'(disp), {8'h0, {8{7'h7F}}});
    chk("rst_ready", 64'(cpu_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    q.push_back(expect_disp(32'(sw), 1'b0));
    model_last = sw;
    rst = 0;
    settle(12);
    chk("sw_36895", 64'(disp), 64'({7'b1000000, 7'b1000000, 7'b1000000, 7'b0110000,
                                    7'b0000010, 7'b0000000, 7'b0010000, 7'b0010010}));
    blank_lz = 1;
    release_pulse();
    settle(12);
    chk("sw_blank", 64'(disp), 64'({{3{7'h7F}}, 7'b0110000,
                                    7'b0000010, 7'b0000000, 7'b0010000, 7'b0010010}));
    blank_lz = 0;
    wait_ready();
    cpu_write(32'hDEADBEEF);
    chk("busy_scan", 64'(busy), 64'd1);
    n = 1;
    while (!cpu_ready && n < 40) begin
      @(negedge clk);
      if (!cpu_ready) n++;
    end
    chk("ready_low_cycles", 64'(n), 64'd9);
    settle(4);
    chk("deadbeef", 64'(disp), 64'(beef));
    sw = sw ^ 18'h1;
    settle(15);
    chk("cpu_mode_sw_ignored", 64'(disp), 64'(beef));
    wait_ready();
    sw = 18'h0ABCD;
    cpu_release = 1;
    cpu_write(32'h1234_5678);
    cpu_release = 0;
    repeat (3) @(negedge clk);
    release_pulse();
    settle(25);
    chk("released_sw", 64'(disp), 64'(expect_disp(32'h0ABCD, 1'b0)));
    wait_ready();
    blank_lz = 1;
    cpu_write(32'h0);
    @(posedge clk);
    @(negedge clk);
    cpu_we = 1;
    cpu_data = $urandom;
    @(negedge clk);
    cpu_we = 0;
    settle(15);
    chk("zero_blank", 64'(disp), 64'({{7{7'h7F}}, 7'b1000000}));
    wait_ready();
    release_pulse();
    settle(12);
    sw = 18'h2F00E;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    void'(q.pop_back());
    @(negedge clk);
    chk("midscan_rst_hex", 64'(disp), {8'h0, {8{7'h7F}}});
    chk("midscan_rst_ready", 64'(cpu_ready), 64'd1);
    q.push_back(expect_disp(32'(sw), blank_lz));
    model_cpu = 0;
    model_last = sw;
    rst = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 30);
    chk("rst_refresh_latency", 64'(n), 64'd10);
    settle(2);
    for (int i = 0; i < 40; i++) begin
      int op;
      logic [17:0] ns;
      wait_ready();
      blank_lz = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 2);
      if (op == 0) cpu_write($urandom);
      else if (op == 1) release_pulse();
      else begin
        ns = 18'($urandom);
        if (!model_cpu && ns != model_last) begin
          q.push_back(expect_disp(32'(ns), blank_lz));
          model_last = ns;
        end
        sw = ns;
      end
      settle(12);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
